rr_mutex: RTL
=============

RR_MUTEX -- requirements
Module: rr_mutex

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum grant-hold cycles before forced release; legal range 2..255.
REQ-002 Parameter GUARD_CYC, default 2, idle cycles between release and next grant; legal range 1..15.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req0, req1  input  1 each  requester n wants the shared latch resource; level, held until granted or abandoned.
REQ-006 Port rel0, rel1  input  1 each  requester n releases; one-cycle pulse, honoured only from the current owner.
REQ-007 Port gnt0, gnt1  output  1 each  grant to requester n; registered, one-hot or zero.
REQ-008 Port s_pulse  output  1  one-cycle set strobe to the external NOR set/reset latch on grant start.
REQ-009 Port r_pulse  output  1  one-cycle reset strobe to the external latch on release.
REQ-010 Port busy  output  1  high in GRANT and GUARD states.
REQ-011 Port owner  output  1  index of the last granted requester; valid while busy.
REQ-012 Port timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT, and GUARD only.
REQ-014 IDLE: with exactly one req high -> GRANT to that requester; both high -> GRANT to the requester selected by prio; none -> stay.
REQ-015 Latency from req sampled high in IDLE to gnt high SHALL be exactly 1 cycle.
REQ-016 On every grant, prio SHALL point to the other requester (round-robin).
REQ-017 s_pulse SHALL be high in the first GRANT cycle only; r_pulse SHALL be high in the first GUARD cycle only; both SHALL never be high together.
REQ-018 GRANT exits to GUARD when the owner's rel is high, or the owner's req is low (abandon), or timeout fires; gnt drops in the same edge.
REQ-019 rel from the non-owner SHALL be ignored; a simultaneous rel and timeout SHALL count as a normal release (timeout stays 0).
REQ-020 GUARD SHALL last exactly GUARD_CYC cycles, then return to IDLE; requests during GUARD are held, not lost.
REQ-021 A hold counter SHALL clear on GRANT entry and increment each GRANT cycle; width is 8 bits, no wrap within the legal range.
REQ-022 gnt0 and gnt1 SHALL never be high in the same cycle (latch S/R exclusivity).

Reset
REQ-023 rst_n low SHALL force IDLE, prio=0 (req0 wins the first tie), counters 0, and all outputs 0, asynchronously.
REQ-024 Reset during GRANT SHALL drop gnt without issuing r_pulse; the first grant after reset SHALL issue s_pulse normally.

Configuration
REQ-025 Macro RR_MUTEX_TIMEOUT_EN defined: GRANT reaching hold count MAX_HOLD-1 forces release, with timeout pulsed in the first GUARD cycle.
REQ-026 Macro RR_MUTEX_TIMEOUT_EN undefined: no forced release, the grant is held indefinitely, and timeout is tied to 0.

Structure
REQ-027 Package rr_mutex_pkg SHALL hold the state enum (IDLE/GRANT/GUARD) and the counter width constants.
REQ-028 Hold and guard counting SHALL live in the sub-module rr_mutex_timer (load, enable, terminal-count output); the FSM stays in rr_mutex.

Verification
REQ-029 Reset then req0=1 at cycle 3 -> gnt0=1 and s_pulse=1 at cycle 4; rel0 at cycle 6 -> gnt0=0 and r_pulse=1 at cycle 7; IDLE at cycle 9.
REQ-030 req0=req1=1 from reset -> grants go 0, 1, 0, 1 across four release cycles, separated by 2 idle guard cycles each.
REQ-031 Owner is 0 and rel1 pulses -> no state change; gnt0 stays 1.
REQ-032 With RR_MUTEX_TIMEOUT_EN and MAX_HOLD=4, hold req0 without rel -> gnt0 high for 4 cycles, then timeout=1 and r_pulse=1 together.
REQ-033 rst_n low mid-GRANT -> gnt=0, busy=0, and r_pulse=0 immediately; after release, a tie goes to req0.
REQ-034 Owner drops req1 in GRANT -> GUARD with r_pulse=1; every cycle, assert !(gnt0 && gnt1) and !(s_pulse && r_pulse).

Source files
------------

// File: rtl/rr_mutex_pkg.sv
// Shared types and constants for the round-robin mutex.
//   state_e  : arbiter FSM states (idle, grant held, post-release guard)
//   CNT_W    : width of the hold and guard counters
//   CNT_SAT  : counter saturation value (counters never wrap)
package rr_mutex_pkg;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGuard = 2'd2
    } state_e;

endpackage

// File: rtl/rr_mutex_timer.sv
// Saturating up-counter with terminal-count detect, used for grant-hold and guard timing.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count to zero (wins over en)
//   en         : increment the count by one, saturating at CNT_SAT
//   tc         : high while the count equals TERMINAL
module rr_mutex_timer
    import rr_mutex_pkg::*;
#(
    parameter int unsigned TERMINAL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en && (count_q != CNT_SAT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/rr_mutex.sv
// Two-requester round-robin mutex driving an external NOR set/reset latch.
// Optional forced release after MAX_HOLD grant cycles is built when RR_MUTEX_TIMEOUT_EN is defined.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req0, req1   : level requests, held until granted or abandoned
//   rel0, rel1   : one-cycle release pulses, only the owner's is honoured
//   gnt0, gnt1   : grants, one-hot or zero
//   s_pulse      : latch set strobe, first grant cycle
//   r_pulse      : latch reset strobe, first guard cycle
//   busy         : high while granted or guarding
//   owner        : index of the last granted requester
//   timeout      : one-cycle pulse on forced release
module rr_mutex
    import rr_mutex_pkg::*;
#(
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned GUARD_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic rel0,
    input  logic rel1,
    output logic gnt0,
    output logic gnt1,
    output logic s_pulse,
    output logic r_pulse,
    output logic busy,
    output logic owner,
    output logic timeout
);

    state_e state_q, state_d;
    logic   prio_q, prio_d;
    logic   owner_q, owner_d;
    logic   s_q, s_d;
    logic   r_q, r_d;
    logic   to_q, to_d;

    logic hold_load, hold_en, hold_tc;
    logic guard_load, guard_en, guard_tc;
    logic force_rel;
    logic own_req, own_rel;

    rr_mutex_timer #(
        .TERMINAL (MAX_HOLD - 1)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load),
        .en    (hold_en),
        .tc    (hold_tc)
    );

    rr_mutex_timer #(
        .TERMINAL (GUARD_CYC - 1)
    ) u_guard_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (guard_load),
        .en    (guard_en),
        .tc    (guard_tc)
    );

`ifdef RR_MUTEX_TIMEOUT_EN
    assign force_rel = hold_tc;
`else
    logic unused_hold_tc;
    assign unused_hold_tc = hold_tc;
    assign force_rel      = 1'b0;
`endif

    assign own_req = owner_q ? req1 : req0;
    assign own_rel = owner_q ? rel1 : rel0;

    assign hold_en  = (state_q == StGrant);
    assign guard_en = (state_q == StGuard);

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        to_d       = 1'b0;
        hold_load  = 1'b0;
        guard_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d   = StGrant;
                    // A lone request wins outright; a tie goes to prio.
                    owner_d   = (req0 && req1) ? prio_q : req1;
                    prio_d    = ~owner_d;
                    s_d       = 1'b1;
                    hold_load = 1'b1;
                end
            end
            StGrant: begin
                if (own_rel || !own_req || force_rel) begin
                    state_d    = StGuard;
                    r_d        = 1'b1;
                    // An explicit release or abandon in the same cycle is a normal release.
                    to_d       = force_rel && !own_rel && own_req;
                    guard_load = 1'b1;
                end
            end
            StGuard: begin
                if (guard_tc) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            s_q     <= s_d;
            r_q     <= r_d;
            to_q    <= to_d;
        end
    end

    assign gnt0    = (state_q == StGrant) && !owner_q;
    assign gnt1    = (state_q == StGrant) && owner_q;
    assign busy    = (state_q != StIdle);
    assign owner   = owner_q;
    assign s_pulse = s_q;
    assign r_pulse = r_q;
    assign timeout = to_q;

endmodule
